// File: rtl/fm_sb_pkg.sv
// Shared types and default constants for the spy-buffer freeze sequencer.
// State encodings are visible to software through state_o.
package fm_sb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_FROZEN = 3'd3,
        ST_INIT   = 3'd4
    } fm_sb_state_e;

    localparam int SB_N_DEF        = 128;
    localparam int PB_MODE_W_DEF   = 2;
    localparam int POST_W_DEF      = 16;
    localparam int INIT_CYC_DEF    = 8;
    localparam int RST_STRETCH_DEF = 4;
    localparam int TRIG_CNT_W      = 16;

    function automatic logic [TRIG_CNT_W-1:0] sat_inc(
        input logic [TRIG_CNT_W-1:0] v
    );
        return (&v) ? v : v + TRIG_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fm_sb_freeze_seq_if.sv
// Control/status bundle of the freeze sequencer.
// FM_SB_EXT_TRIG_EN adds the ext_trig_i pulse input.
interface fm_sb_freeze_seq_if
    import fm_sb_pkg::*;
#(
    parameter int SB_N      = SB_N_DEF,
    parameter int PB_MODE_W = PB_MODE_W_DEF,
    parameter int POST_W    = POST_W_DEF
);

    logic                      arm_i;
    logic                      sw_trig_i;
    logic                      release_i;
    logic                      init_req_i;
`ifdef FM_SB_EXT_TRIG_EN
    logic                      ext_trig_i;
`endif
    logic [POST_W-1:0]         post_trig_i;
    logic [PB_MODE_W-1:0]      pb_mode_i;
    logic [SB_N-1:0]           freeze_mask_i;
    logic [SB_N-1:0]           pb_mask_i;
    logic [SB_N-1:0]           sb_reset_i;
    logic [SB_N-1:0]           freeze_o;
    logic [SB_N*PB_MODE_W-1:0] pb_mode_o;
    logic                      init_spy_mem_o;
    logic [SB_N-1:0]           sb_reset_o;
    logic [2:0]                state_o;
    logic [TRIG_CNT_W-1:0]     trig_cnt_o;

    modport master (
`ifdef FM_SB_EXT_TRIG_EN
        output ext_trig_i,
`endif
        output arm_i, sw_trig_i, release_i, init_req_i,
        output post_trig_i, pb_mode_i,
        output freeze_mask_i, pb_mask_i, sb_reset_i,
        input  freeze_o, pb_mode_o, init_spy_mem_o,
        input  sb_reset_o, state_o, trig_cnt_o
    );

    modport slave (
`ifdef FM_SB_EXT_TRIG_EN
        input  ext_trig_i,
`endif
        input  arm_i, sw_trig_i, release_i, init_req_i,
        input  post_trig_i, pb_mode_i,
        input  freeze_mask_i, pb_mask_i, sb_reset_i,
        output freeze_o, pb_mode_o, init_spy_mem_o,
        output sb_reset_o, state_o, trig_cnt_o
    );

endinterface

// File: rtl/fm_sb_rst_stretch.sv
// Per-channel reset stretcher: each rising edge of req yields a pulse
// RST_STRETCH cycles long; a new edge mid-pulse restarts the count.
module fm_sb_rst_stretch #(
    parameter int RST_STRETCH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic pulse
);

    localparam int CW = $clog2(RST_STRETCH + 1);

    logic          req_q;
    logic          rise;
    logic [CW-1:0] cnt;

    assign rise = req & ~req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            req_q <= req;
            if (rise) begin
                cnt   <= CW'(RST_STRETCH);
                pulse <= 1'b1;
            end else if (cnt != '0) begin
                cnt   <= cnt - CW'(1);
                pulse <= (cnt != CW'(1));
            end
        end
    end

endmodule

// File: rtl/fm_sb_freeze_seq.sv
// Spy-buffer freeze sequencer: arm/trigger/post-delay/freeze/init FSM.
// Define FM_SB_EXT_TRIG_EN to OR ext_trig_i into the trigger.
module fm_sb_freeze_seq
    import fm_sb_pkg::*;
#(
    parameter int SB_N        = SB_N_DEF,
    parameter int PB_MODE_W   = PB_MODE_W_DEF,
    parameter int POST_W      = POST_W_DEF,
    parameter int INIT_CYC    = INIT_CYC_DEF,
    parameter int RST_STRETCH = RST_STRETCH_DEF
) (
    input logic                axi_clk,
    input logic                axi_reset_n,
    fm_sb_freeze_seq_if.slave  bus
);

    localparam int IW = $clog2(INIT_CYC + 1);

    fm_sb_state_e              state;
    logic [POST_W-1:0]         post_cnt;
    logic [IW-1:0]             init_cnt;
    logic                      init_spy;
    logic [TRIG_CNT_W-1:0]     trig_cnt;
    logic [SB_N-1:0]           freeze;
    logic [SB_N*PB_MODE_W-1:0] pb_mode;
    logic [SB_N-1:0]           sb_rst;

    logic arm_q, trig_q, rel_q, init_q;
    logic arm_rise, rel_rise, init_rise, trig;

    assign arm_rise  = bus.arm_i      & ~arm_q;
    assign rel_rise  = bus.release_i  & ~rel_q;
    assign init_rise = bus.init_req_i & ~init_q;
`ifdef FM_SB_EXT_TRIG_EN
    assign trig = (bus.sw_trig_i & ~trig_q) | bus.ext_trig_i;
`else
    assign trig = bus.sw_trig_i & ~trig_q;
`endif

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            arm_q  <= 1'b0;
            trig_q <= 1'b0;
            rel_q  <= 1'b0;
            init_q <= 1'b0;
        end else begin
            arm_q  <= bus.arm_i;
            trig_q <= bus.sw_trig_i;
            rel_q  <= bus.release_i;
            init_q <= bus.init_req_i;
        end
    end

    // An init request preempts every state except INIT itself
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state    <= ST_IDLE;
            post_cnt <= '0;
            init_cnt <= '0;
            init_spy <= 1'b0;
            trig_cnt <= '0;
        end else if (init_rise && state != ST_INIT) begin
            state    <= ST_INIT;
            init_cnt <= IW'(INIT_CYC);
            init_spy <= 1'b1;
            trig_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arm_rise)
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig) begin
                        trig_cnt <= sat_inc(trig_cnt);
                        if (bus.post_trig_i == '0) begin
                            state <= ST_FROZEN;
                        end else begin
                            state    <= ST_POST;
                            post_cnt <= bus.post_trig_i;
                        end
                    end else if (!bus.arm_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_POST: begin
                    if (post_cnt == POST_W'(1))
                        state <= ST_FROZEN;
                    else
                        post_cnt <= post_cnt - POST_W'(1);
                end
                ST_FROZEN: begin
                    if (rel_rise)
                        state <= ST_IDLE;
                end
                ST_INIT: begin
                    if (init_cnt == IW'(1)) begin
                        state    <= ST_IDLE;
                        init_spy <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt - IW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            freeze  <= '0;
            pb_mode <= '0;
        end else begin
            freeze <= (state == ST_FROZEN) ? ~bus.freeze_mask_i : '0;
            for (int i = 0; i < SB_N; i++) begin
                pb_mode[i*PB_MODE_W +: PB_MODE_W] <=
                    (state == ST_INIT || bus.pb_mask_i[i]) ? '0 : bus.pb_mode_i;
            end
        end
    end

    for (genvar g = 0; g < SB_N; g++) begin : g_ch
        fm_sb_rst_stretch #(
            .RST_STRETCH (RST_STRETCH)
        ) u_stretch (
            .clk   (axi_clk),
            .rst_n (axi_reset_n),
            .req   (bus.sb_reset_i[g]),
            .pulse (sb_rst[g])
        );
    end

    assign bus.freeze_o       = freeze;
    assign bus.pb_mode_o      = pb_mode;
    assign bus.init_spy_mem_o = init_spy;
    assign bus.sb_reset_o     = sb_rst;
    assign bus.state_o        = state;
    assign bus.trig_cnt_o     = trig_cnt;

endmodule

// File: tb/tb_fm_sb_freeze_seq.sv
// Bench for fm_sb_freeze_seq: directed sequences plus randomized
// freeze scenarios and sb_reset traffic against a timing-rule model.
module tb_fm_sb_freeze_seq;

    localparam int N  = 128;
    localparam int PW = 2;
    localparam int TW = 16;
    localparam int ST = 4;

    logic axi_clk = 1'b0;
    logic axi_reset_n = 1'b0;

    always #5 axi_clk = ~axi_clk;

    fm_sb_freeze_seq_if #(.SB_N(N), .PB_MODE_W(PW), .POST_W(TW)) bus ();

    fm_sb_freeze_seq #(
        .SB_N(N), .PB_MODE_W(PW), .POST_W(TW),
        .INIT_CYC(8), .RST_STRETCH(ST)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic logic [N-1:0] rnd_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N-1:0] inv(input logic [N-1:0] m);
        return ~m;
    endfunction

    function automatic logic [N*PW-1:0] exp_pb(input logic [N-1:0] m,
                                               input logic [PW-1:0] mode);
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = m[i] ? '0 : mode;
        return r;
    endfunction

    task automatic arm_up();
        bus.arm_i = 1'b0;
        tick();
        bus.arm_i = 1'b1;
        tick();
    endtask

    task automatic fire(input int p);
        bus.post_trig_i = TW'(p);
        bus.sw_trig_i = 1'b1;
        tick();
        bus.sw_trig_i = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]    mask;
        logic [N-1:0]    pmask;
        logic [PW-1:0]   mode;
        logic [N-1:0]    sv;
        logic [N-1:0]    prev;
        logic [N-1:0]    exp_sb;
        int              last [N];
        int              hi3;
        int              p;
        bit              abort;

        bus.arm_i = 0; bus.sw_trig_i = 0; bus.release_i = 0;
        bus.init_req_i = 0; bus.post_trig_i = '0; bus.pb_mode_i = 2'd3;
        bus.freeze_mask_i = '0; bus.pb_mask_i = '0; bus.sb_reset_i = '0;
`ifdef FM_SB_EXT_TRIG_EN
        bus.ext_trig_i = 0;
`endif
        repeat (3) tick();
        check("rst_state", bus.state_o, 3'd0);
        check("rst_freeze", bus.freeze_o, '0);
        check("rst_pb", bus.pb_mode_o, '0);
        check("rst_init", bus.init_spy_mem_o, 1'b0);
        check("rst_sbr", bus.sb_reset_o, '0);
        check("rst_cnt", bus.trig_cnt_o, '0);
        axi_reset_n = 1'b1;
        tick();

        // immediate freeze with a byte-pattern mask
        mask = {16{8'hF0}};
        pmask = rnd_vec();
        mode = 2'd2;
        bus.freeze_mask_i = mask;
        bus.pb_mask_i = pmask;
        bus.pb_mode_i = mode;
        arm_up();
        check("armed", bus.state_o, 3'd1);
        fire(0);
        check("frozen_state", bus.state_o, 3'd3);
        check("freeze_lag", bus.freeze_o, '0);
        tick();
        check("freeze_f0", bus.freeze_o, inv(mask));
        check("cnt_one", bus.trig_cnt_o, 16'(exp_cnt));
        check("pb_mode", bus.pb_mode_o, exp_pb(pmask, mode));
        mask = rnd_vec();
        bus.freeze_mask_i = mask;
        tick();
        check("mask_live", bus.freeze_o, inv(mask));
        bus.release_i = 1'b1;
        tick();
        bus.release_i = 1'b0;
        check("released", bus.state_o, 3'd0);
        tick();
        check("unfrozen", bus.freeze_o, '0);

        // post delay of 5 with a trigger ignored in POST
        arm_up();
        fire(5);
        check("post_state", bus.state_o, 3'd2);
        for (int j = 1; j <= 6; j++) begin
            if (j == 2) bus.sw_trig_i = 1'b1;
            if (j == 3) bus.sw_trig_i = 1'b0;
            tick();
            check($sformatf("post5_j%0d", j), bus.freeze_o,
                  (j == 6) ? inv(mask) : '0);
        end
        check("cnt_post", bus.trig_cnt_o, 16'(exp_cnt));

        // init and release together in FROZEN: init wins
        bus.arm_i = 1'b0;
        bus.init_req_i = 1'b1;
        bus.release_i = 1'b1;
        tick();
        exp_cnt = 0;
        bus.init_req_i = 1'b0;
        bus.release_i = 1'b0;
        check("init_state", bus.state_o, 3'd4);
        check("init_cnt_clr", bus.trig_cnt_o, 16'(exp_cnt));
        check("init_pulse0", bus.init_spy_mem_o, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) bus.arm_i = 1'b1;
            if (j == 4) bus.init_req_i = 1'b1;
            if (j == 5) bus.init_req_i = 1'b0;
            tick();
            check($sformatf("init_j%0d", j), bus.init_spy_mem_o, j < 8);
            check($sformatf("init_frz_j%0d", j), bus.freeze_o, '0);
            if (j == 1) check("init_pb0", bus.pb_mode_o, '0);
        end
        check("init_done", bus.state_o, 3'd0);
        tick();
        check("init_ign_arm", bus.state_o, 3'd0);

        // sb_reset stretching: directed double rise on bit 3, then random
        prev = '0;
        hi3 = 0;
        for (int i = 0; i < N; i++) last[i] = -100;
        for (int t = 0; t < 40; t++) begin
            if (t < 9) begin
                sv = '0;
                sv[3] = (t == 0 || t == 2);
            end else begin
                sv = rnd_vec() & rnd_vec();
            end
            bus.sb_reset_i = sv;
            tick();
            for (int i = 0; i < N; i++) begin
                if (sv[i] && !prev[i]) last[i] = t;
                exp_sb[i] = (t - last[i]) < ST;
            end
            prev = sv;
            if (t < 9 && bus.sb_reset_o[3]) hi3++;
            check($sformatf("sbr_t%0d", t), bus.sb_reset_o, exp_sb);
        end
        check("sbr3_len", hi3, 6);
        bus.sb_reset_i = '0;
        repeat (ST + 1) tick();
        check("sbr_idle", bus.sb_reset_o, '0);

        // async reset in the middle of a post delay
        arm_up();
        fire(5);
        tick();
        tick();
        check("post_mid", bus.state_o, 3'd2);
        #2;
        axi_reset_n = 1'b0;
        #1;
        check("arst_state", bus.state_o, 3'd0);
        check("arst_freeze", bus.freeze_o, '0);
        check("arst_cnt", bus.trig_cnt_o, '0);
        bus.arm_i = 1'b0;
        exp_cnt = 0;
        tick();
        tick();
        axi_reset_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("arst_nofrz%0d", j), bus.freeze_o, '0);
        end
        check("arst_idle", bus.state_o, 3'd0);

        // randomized freeze scenarios
        for (int it = 0; it < 24; it++) begin
            mask = rnd_vec();
            pmask = rnd_vec();
            mode = PW'($urandom);
            bus.freeze_mask_i = mask;
            bus.pb_mask_i = pmask;
            bus.pb_mode_i = mode;
            p = $urandom_range(0, 6);
            abort = ($urandom_range(0, 3) == 0) && (p >= 2);
            arm_up();
            if ($urandom_range(0, 4) == 0) begin
                bus.arm_i = 1'b0;
                tick();
                check("r_disarm", bus.state_o, 3'd0);
                arm_up();
            end
            fire(p);
            check("r_cnt", bus.trig_cnt_o, 16'(exp_cnt));
            if (abort) begin
                tick();
                bus.init_req_i = 1'b1;
                tick();
                bus.init_req_i = 1'b0;
                exp_cnt = 0;
                check("r_abort", bus.state_o, 3'd4);
                check("r_abort_cnt", bus.trig_cnt_o, 16'(exp_cnt));
                repeat (9) tick();
                check("r_abort_idle", bus.state_o, 3'd0);
                check("r_abort_frz", bus.freeze_o, '0);
            end else begin
                for (int j = 1; j <= p + 1; j++) begin
                    tick();
                    check($sformatf("r_frz_p%0d_j%0d", p, j), bus.freeze_o,
                          (j == p + 1) ? inv(mask) : '0);
                end
                check("r_pb", bus.pb_mode_o, exp_pb(pmask, mode));
                bus.release_i = 1'b1;
                tick();
                bus.release_i = 1'b0;
                tick();
                check("r_rel", bus.state_o, 3'd0);
            end
        end

`ifdef FM_SB_EXT_TRIG_EN
        bus.arm_i = 1'b0;
        tick();
        bus.ext_trig_i = 1'b1;
        tick();
        bus.ext_trig_i = 1'b0;
        tick();
        check("ext_idle", bus.state_o, 3'd0);
        check("ext_idle_cnt", bus.trig_cnt_o, 16'(exp_cnt));
        arm_up();
        bus.post_trig_i = '0;
        bus.ext_trig_i = 1'b1;
        tick();
        bus.ext_trig_i = 1'b0;
        exp_cnt++;
        check("ext_frozen", bus.state_o, 3'd3);
        check("ext_cnt", bus.trig_cnt_o, 16'(exp_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fm_sb_freeze_seq.md
FM_SB_FREEZE_SEQ -- requirements
Module: fm_sb_freeze_seq

Interface
REQ-001 SHALL have parameter SB_N, default 128: number of spy-buffer channels, legal 1..512.
REQ-002 SHALL have parameter PB_MODE_W, default 2: playback-mode field width.
REQ-003 SHALL have parameter POST_W, default 16: post-trigger delay counter width.
REQ-004 SHALL have parameter INIT_CYC, default 8: init pulse length in cycles, legal >=1.
REQ-005 SHALL have parameter RST_STRETCH, default 4: per-channel reset pulse length in cycles, legal >=1.
REQ-006 SHALL have ports:
- axi_clk  in  1  sole clock
- axi_reset_n  in  1  asynchronous, active-low reset
- arm_i  in  1  software arm level
- sw_trig_i  in  1  software freeze-trigger level
- release_i  in  1  software unfreeze level
- init_req_i  in  1  spy-memory init request level
- ext_trig_i  in  1  external trigger pulse, only when FM_SB_EXT_TRIG_EN
- post_trig_i  in  POST_W  cycles between trigger and freeze
- pb_mode_i  in  PB_MODE_W  global playback mode
- freeze_mask_i  in  SB_N  1 = channel excluded from freeze
- pb_mask_i  in  SB_N  1 = channel forced to playback mode 0
- sb_reset_i  in  SB_N  per-channel reset request level
- freeze_o  out  SB_N  per-channel freeze
- pb_mode_o  out  SB_N*PB_MODE_W  per-channel playback mode, channel i at bits [i*PB_MODE_W +: PB_MODE_W]
- init_spy_mem_o  out  1  init pulse
- sb_reset_o  out  SB_N  stretched per-channel reset
- state_o  out  3  FSM state encoding
- trig_cnt_o  out  16  accepted-trigger count

Function
REQ-007 SHALL edge-detect arm_i, sw_trig_i, release_i, init_req_i and sb_reset_i[i] internally; only rising edges act.
REQ-008 SHALL implement FSM IDLE=0, ARMED=1, POST=2, FROZEN=3, INIT=4.
REQ-009 IDLE: init rise -> INIT; else arm rise -> ARMED.
REQ-010 ARMED: init rise -> INIT; else trigger with post_trig_i==0 -> FROZEN; else trigger -> POST, latching post_trig_i into down-counter; else arm_i low -> IDLE.
REQ-011 POST: counter decrements each cycle and reaches FROZEN after exactly post_trig_i cycles; triggers ignored; init rise aborts to INIT.
REQ-012 FROZEN: release rise -> IDLE; init rise -> INIT (init wins over simultaneous release); triggers ignored.
REQ-013 INIT: init_spy_mem_o high for exactly INIT_CYC cycles, then IDLE; all other requests ignored.
REQ-014 Trigger = sw_trig_i rise, OR-ed with ext_trig_i when compiled in; freeze_o asserts on the edge after FROZEN is entered (trigger at edge k -> freeze_o high from edge k+1+post_trig_i).
REQ-015 freeze_o[i] = (state==FROZEN) & ~freeze_mask_i[i], registered; mask changes take effect after one cycle, including while FROZEN.
REQ-016 pb_mode_o channel i = pb_mask_i[i] ? 0 : pb_mode_i, registered; forced 0 in INIT.
REQ-017 sb_reset_o[i] high for exactly RST_STRETCH cycles after each sb_reset_i[i] rise; a new rise while active restarts the count.
REQ-018 trig_cnt_o increments per accepted trigger (ARMED only), saturates at 0xFFFF, clears on INIT entry.

Reset
REQ-019 axi_reset_n low asynchronously SHALL force state IDLE, all outputs 0, all counters and edge-detect history registers 0.
REQ-020 Reset mid-POST or mid-INIT SHALL abandon the sequence; no residual pulse after release of reset.

Configuration
REQ-021 With FM_SB_EXT_TRIG_EN defined, port ext_trig_i exists and is a trigger source; without it, the port is absent and only sw_trig_i triggers.

Structure
REQ-022 State enum, state encodings and default parameter constants SHALL live in package fm_sb_pkg.
REQ-023 Per-channel stretcher SHALL be sub-module fm_sb_rst_stretch, generate-instantiated SB_N times.

Verification
REQ-024 Bench SHALL check: arm, sw_trig with post_trig_i=0, freeze_mask_i=0x...F0 -> freeze_o=~mask one cycle later, trig_cnt_o=1.
REQ-025 Bench SHALL check: post_trig_i=5, trigger at edge k -> freeze_o first high at edge k+6; second trigger during POST does not change trig_cnt_o.
REQ-026 Bench SHALL check: init rise and release rise in the same cycle in FROZEN -> INIT, init_spy_mem_o high 8 cycles, freeze_o 0, trig_cnt_o 0.
REQ-027 Bench SHALL check: sb_reset_i[3] rises, then rises again 2 cycles later -> sb_reset_o[3] high 6 cycles total, other bits 0.
REQ-028 Bench SHALL check: axi_reset_n low during POST with count 3 remaining -> state_o=0, freeze_o=0 immediately, no freeze after reset release.
REQ-029 Bench SHALL check, with FM_SB_EXT_TRIG_EN: ext_trig_i pulse while ARMED, post_trig_i=0 -> FROZEN; same pulse in IDLE -> no effect.
